// File: rtl/stage_if_fq.sv
// stage_if_fq: fetch stage with a small fetch queue, directly upstream of stage_id.
//   Generates sequential PCs and keeps at most one request in flight to the
//   variable-latency instruction memory. It buffers returned instructions and
//   presents the oldest to dispatch under a valid/ready handshake. A redirect
//   from retire flushes the queue and squashes any in-flight response.
// Ports:
//   clock, reset                     posedge clock, synchronous active-high reset
//   proc2Imem_req / proc2Imem_addr   request strobe (one-cycle) and 8-byte line address
//   Imem2proc_valid / Imem2proc_data response for the outstanding request
//   redirect_en / redirect_pc        flush and restart fetch at redirect_pc (bits [1:0] ignored)
//   id_ready                         dispatch accepts the head entry this cycle
//   if_valid/if_inst/if_pc/if_npc    head entry (NOP/0/0 when empty)
//   fq_count                         occupied queue entries
module stage_if_fq #(
  parameter int          IQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic                        proc2Imem_req,
  output logic [31:0]                 proc2Imem_addr,
  input  logic                        Imem2proc_valid,
  input  logic [63:0]                 Imem2proc_data,
  input  logic                        redirect_en,
  input  logic [31:0]                 redirect_pc,
  input  logic                        id_ready,
  output logic                        if_valid,
  output logic [31:0]                 if_inst,
  output logic [31:0]                 if_pc,
  output logic [31:0]                 if_npc,
  output logic [$clog2(IQ_DEPTH):0]   fq_count
);
  localparam int          PW      = $clog2(IQ_DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_entry_t;

  fq_entry_t     fq_mem [IQ_DEPTH];
  fq_entry_t     head_e;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, reserve;
  logic [31:0]   pc, req_pc, addr_q, fetch_line, resp_inst;
  logic          outstanding, drop;
  logic          resp, accept, push, pop, issue;
  logic          unused_rpc_lsbs;

  assign unused_rpc_lsbs = ^redirect_pc[1:0];

  // A response only counts when a request is actually in flight.
  assign resp      = Imem2proc_valid && outstanding;
  assign accept    = resp && !drop;
  assign push      = accept && !redirect_en;
  assign pop       = if_valid && id_ready && !redirect_en;
  assign resp_inst = req_pc[2] ? Imem2proc_data[63:32] : Imem2proc_data[31:0];

  // Credit check: a slot must exist for the new request's eventual response,
  // counting the entry being written this cycle. Same-cycle pops are not
  // credited, which keeps the check independent of id_ready timing.
  assign reserve    = count + {{(CW-1){1'b0}}, accept};
  assign fetch_line = {pc[31:3], 3'b000};
  assign issue      = !reset && !redirect_en && (!outstanding || resp) && (reserve < DEPTH_C);

  assign proc2Imem_req  = issue;
  assign proc2Imem_addr = issue ? fetch_line : addr_q;

  // Head entry drives if_* combinationally.
  assign head_e   = fq_mem[head];
  assign if_valid = (count != '0);
  assign if_inst  = if_valid ? head_e.inst : NOP;
  assign if_pc    = if_valid ? head_e.pc : 32'h0;
  assign if_npc   = if_valid ? head_e.pc + 32'd4 : 32'h0;
  assign fq_count = count;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      req_pc      <= 32'h0;
      addr_q      <= 32'h0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect_en) begin
      pc          <= {redirect_pc[31:2], 2'b00};
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      // The in-flight response still comes back later and must be thrown away.
      // A response landing this cycle is consumed here instead.
      drop        <= outstanding && !resp;
      outstanding <= outstanding && !resp;
    end else begin
      if (issue) begin
        req_pc <= pc;
        pc     <= pc + 32'd4;
        addr_q <= fetch_line;
      end
      if (issue)     outstanding <= 1'b1;
      else if (resp) outstanding <= 1'b0;
      if (resp)      drop        <= 1'b0;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) fq_mem[tail] <= '{inst: resp_inst, pc: req_pc};
  end

  // The credit check should make this unreachable.
  always_ff @(posedge clock) begin
    if (!reset && push && !pop) assert (count != DEPTH_C);
  end
endmodule
